clock_time_setter: RTL and testbench

//  User-input side of the digital clock: conditions three raw pushbuttons and runs a set-time FSM.

---
 rtl/clock_time_setter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_clock_time_setter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_setter.sv
// -----------------------------------------------------------------------------
// clock_time_setter
//
// User-input side of the digital clock. Three raw active-low pushbuttons are
// synchronised and debounced into one-cycle press events, which drive a
// set-time FSM:
//   RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN   (on each mode press)
// Entering SET_HOUR snapshots the live counter values into edit registers.
// Inc/dec presses in a SET state wrap-edit the selected field. Each edit
// issues a one-cycle load strobe for that field. Leaving SET_SEC issues one
// cycle with all three load strobes set, so the counters are committed together.
// While editing, the selected display pair blinks through blank_mask.
//
// Ports
//   clk_in_50M            in   system clock
//   rst_n                 in   asynchronous active-low reset
//   key_mode_n            in   raw mode key, active-low, asynchronous
//   key_inc_n             in   raw increment key, active-low, asynchronous
//   key_dec_n             in   raw decrement key, active-low, asynchronous
//   secState/minState/hourState  in [6:0]  live counter values, binary
//   en_sec/en_min/en_hour        out       counter enables (1 = count)
//   load_sec/load_min/load_hour  out       one-cycle load strobes
//   data_sec/data_min/data_hour  out [6:0] preload values (the edit registers)
//   blank_mask            out [2:0] [2]=hour [1]=min [0]=sec, 1 = blank
//   set_mode              out [1:0] 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
// -----------------------------------------------------------------------------
module clock_time_setter #(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int HOUR_MOD     = 24
) (
    input  logic       clk_in_50M,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic [6:0] secState,
    input  logic [6:0] minState,
    input  logic [6:0] hourState,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic       load_sec,
    output logic       load_min,
    output logic       load_hour,
    output logic [6:0] data_sec,
    output logic [6:0] data_min,
    output logic [6:0] data_hour,
    output logic [2:0] blank_mask,
    output logic [1:0] set_mode
);

    // Counter widths: $clog2(N) bits are enough to hold the terminal value N-1.
    localparam int DB_W    = (DB_CYCLES    > 1) ? $clog2(DB_CYCLES)    : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    localparam logic [6:0] HOUR_MAX = 7'(HOUR_MOD - 1);
    localparam logic [6:0] SIX_MAX  = 7'd59;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // Key conditioning: [0]=mode [1]=inc [2]=dec
    // -------------------------------------------------------------------------
    logic [2:0] w_key_raw;
    logic [2:0] w_press;

    assign w_key_raw = {key_dec_n, key_inc_n, key_mode_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic            r_sync1;
            logic            r_sync2;
            logic            r_db;
            logic            r_db_d;
            logic [DB_W-1:0] r_db_cnt;

            // The debounced level only follows the synced level after it has
            // disagreed for DB_CYCLES consecutive cycles; any agreement clears
            // the run, so short glitches never reach r_db.
            always_ff @(posedge clk_in_50M or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1  <= 1'b1;
                    r_sync2  <= 1'b1;
                    r_db     <= 1'b1;
                    r_db_d   <= 1'b1;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1 <= w_key_raw[gi];
                    r_sync2 <= r_sync1;
                    r_db_d  <= r_db;
                    if (r_sync2 == r_db) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db     <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
            end

            // Falling edge of the debounced level only: held keys and
            // releases produce no further events.
            assign w_press[gi] = r_db_d & ~r_db;
        end
    endgenerate

    logic w_mode_evt;
    logic w_inc_evt;
    logic w_dec_evt;

    // Mode has priority; inc and dec together cancel each other.
    assign w_mode_evt = w_press[0];
    assign w_inc_evt  = w_press[1] & ~w_press[2] & ~w_press[0];
    assign w_dec_evt  = w_press[2] & ~w_press[1] & ~w_press[0];

    // -------------------------------------------------------------------------
    // Field helpers
    // -------------------------------------------------------------------------
    function automatic logic [6:0] f_inc(input logic [6:0] v, input logic [6:0] vmax);
        return (v == vmax) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] f_dec(input logic [6:0] v, input logic [6:0] vmax);
        return (v == 7'd0) ? vmax : v - 7'd1;
    endfunction

    // Out-of-range live values are snapshotted as 0 so the edit register is
    // always a legal field value.
    function automatic logic [6:0] f_snap(input logic [6:0] v, input logic [6:0] vmax);
        return (v > vmax) ? 7'd0 : v;
    endfunction

    // -------------------------------------------------------------------------
    // Set-time FSM
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic [6:0]           r_hour;
    logic [6:0]           r_min;
    logic [6:0]           r_sec;
    logic [2:0]           r_load;       // {hour, min, sec}
    logic                 r_en;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_blink;

    state_t               w_state_next;
    logic [6:0]           w_hour_next;
    logic [6:0]           w_min_next;
    logic [6:0]           w_sec_next;
    logic [2:0]           w_load_next;
    logic                 w_en_next;
    logic [BLINK_W-1:0]   w_blink_cnt_next;
    logic                 w_blink_next;
    logic                 w_edit;

    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_hour      <= 7'd0;
            r_min       <= 7'd0;
            r_sec       <= 7'd0;
            r_load      <= 3'b000;
            r_en        <= 1'b1;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hour      <= w_hour_next;
            r_min       <= w_min_next;
            r_sec       <= w_sec_next;
            r_load      <= w_load_next;
            r_en        <= w_en_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink     <= w_blink_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_hour_next      = r_hour;
        w_min_next       = r_min;
        w_sec_next       = r_sec;
        w_load_next      = 3'b000;
        w_edit           = 1'b0;
        w_blink_cnt_next = r_blink_cnt;
        w_blink_next     = r_blink;

        case (r_state)
            ST_RUN: begin
                if (w_mode_evt) begin
                    w_state_next = ST_SET_HOUR;
                    w_hour_next  = f_snap(hourState, HOUR_MAX);
                    w_min_next   = f_snap(minState, SIX_MAX);
                    w_sec_next   = f_snap(secState, SIX_MAX);
                end
            end
            ST_SET_HOUR: begin
                if (w_mode_evt) begin
                    w_state_next = ST_SET_MIN;
                end else if (w_inc_evt || w_dec_evt) begin
                    w_hour_next    = w_inc_evt ? f_inc(r_hour, HOUR_MAX) : f_dec(r_hour, HOUR_MAX);
                    w_load_next[2] = 1'b1;
                    w_edit         = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_evt) begin
                    w_state_next = ST_SET_SEC;
                end else if (w_inc_evt || w_dec_evt) begin
                    w_min_next     = w_inc_evt ? f_inc(r_min, SIX_MAX) : f_dec(r_min, SIX_MAX);
                    w_load_next[1] = 1'b1;
                    w_edit         = 1'b1;
                end
            end
            ST_SET_SEC: begin
                if (w_mode_evt) begin
                    // Commit all three fields together on the way out.
                    w_state_next = ST_RUN;
                    w_load_next  = 3'b111;
                end else if (w_inc_evt || w_dec_evt) begin
                    w_sec_next     = w_inc_evt ? f_inc(r_sec, SIX_MAX) : f_dec(r_sec, SIX_MAX);
                    w_load_next[0] = 1'b1;
                    w_edit         = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // Counting resumes only once RUN has been held for a full cycle, so
        // the commit cycle still sees the counters disabled.
        w_en_next = (r_state == ST_RUN) && (w_state_next == ST_RUN);

        // Blink phase restarts visible on every state change and every edit
        // so the user always sees the new value immediately.
        if ((w_state_next == ST_RUN) || (w_state_next != r_state) || w_edit) begin
            w_blink_cnt_next = '0;
            w_blink_next     = 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_next = '0;
            w_blink_next     = ~r_blink;
        end else begin
            w_blink_cnt_next = r_blink_cnt + BLINK_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic [2:0] w_blank;

    always_comb begin
        w_blank = 3'b000;
        case (r_state)
            ST_SET_HOUR: w_blank[2] = r_blink;
            ST_SET_MIN:  w_blank[1] = r_blink;
            ST_SET_SEC:  w_blank[0] = r_blink;
            default:     w_blank    = 3'b000;
        endcase
    end

    assign en_sec     = r_en;
    assign en_min     = r_en;
    assign en_hour    = r_en;
    assign load_hour  = r_load[2];
    assign load_min   = r_load[1];
    assign load_sec   = r_load[0];
    assign data_hour  = r_hour;
    assign data_min   = r_min;
    assign data_sec   = r_sec;
    assign blank_mask = w_blank;
    assign set_mode   = r_state;

endmodule

// File: tb/tb_clock_time_setter.sv
module tb_clock_time_setter;

    localparam int DB    = 4;
    localparam int BLINK = 8;
    localparam int HMOD  = 24;

    logic       clk;
    logic       rst_n;
    logic       key_mode_n, key_inc_n, key_dec_n;
    logic [6:0] secState, minState, hourState;
    logic       en_sec, en_min, en_hour;
    logic       load_sec, load_min, load_hour;
    logic [6:0] data_sec, data_min, data_hour;
    logic [2:0] blank_mask;
    logic [1:0] set_mode;

    clock_time_setter #(.DB_CYCLES(DB), .BLINK_CYCLES(BLINK), .HOUR_MOD(HMOD)) dut (
        .clk_in_50M (clk),
        .rst_n      (rst_n),
        .key_mode_n (key_mode_n),
        .key_inc_n  (key_inc_n),
        .key_dec_n  (key_dec_n),
        .secState   (secState),
        .minState   (minState),
        .hourState  (hourState),
        .en_sec     (en_sec),
        .en_min     (en_min),
        .en_hour    (en_hour),
        .load_sec   (load_sec),
        .load_min   (load_min),
        .load_hour  (load_hour),
        .data_sec   (data_sec),
        .data_min   (data_min),
        .data_hour  (data_hour),
        .blank_mask (blank_mask),
        .set_mode   (set_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: key = sampled level two clocks late, accepted
    // after DB consecutive disagreeing samples, event on accepted fall.
    // Time setting is plain modular arithmetic; blink is derived from the
    // number of cycles since the last restart.
    // ------------------------------------------------------------------
    int m_p1[3], m_p2[3], m_lvl[3], m_lvl_prev[3], m_run[3];
    int m_mode, m_hour, m_min, m_sec, m_ticks;
    bit m_lh, m_lm, m_ls, m_en;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_p1[k] = 1; m_p2[k] = 1; m_lvl[k] = 1; m_lvl_prev[k] = 1; m_run[k] = 0;
        end
        m_mode = 0; m_hour = 0; m_min = 0; m_sec = 0; m_ticks = 0;
        m_lh = 0; m_lm = 0; m_ls = 0; m_en = 1;
    endtask

    task automatic model_step();
        int raw[3];
        int evt[3];
        int s;
        int old_mode;
        bit restart, mode_e, inc_e, dec_e;
        raw[0] = int'(key_mode_n);
        raw[1] = int'(key_inc_n);
        raw[2] = int'(key_dec_n);
        for (int k = 0; k < 3; k++) begin
            evt[k] = (m_lvl_prev[k] == 1 && m_lvl[k] == 0) ? 1 : 0;
            m_lvl_prev[k] = m_lvl[k];
            s = m_p2[k];
            m_p2[k] = m_p1[k];
            m_p1[k] = raw[k];
            if (s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_lvl[k] = s;
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        mode_e = (evt[0] == 1);
        inc_e  = (evt[1] == 1) && (evt[2] == 0) && !mode_e;
        dec_e  = (evt[2] == 1) && (evt[1] == 0) && !mode_e;
        m_lh = 0; m_lm = 0; m_ls = 0;
        restart  = 0;
        old_mode = m_mode;
        if (mode_e) begin
            if (m_mode == 0) begin
                m_hour = (int'(hourState) >= HMOD) ? 0 : int'(hourState);
                m_min  = (int'(minState)  >= 60)   ? 0 : int'(minState);
                m_sec  = (int'(secState)  >= 60)   ? 0 : int'(secState);
                m_mode = 1;
            end else if (m_mode == 3) begin
                m_lh = 1; m_lm = 1; m_ls = 1;
                m_mode = 0;
            end else begin
                m_mode = m_mode + 1;
            end
        end else if (m_mode != 0 && (inc_e || dec_e)) begin
            restart = 1;
            case (m_mode)
                1: begin m_hour = inc_e ? (m_hour + 1) % HMOD : (m_hour + HMOD - 1) % HMOD; m_lh = 1; end
                2: begin m_min  = inc_e ? (m_min + 1) % 60 : (m_min + 59) % 60; m_lm = 1; end
                default: begin m_sec = inc_e ? (m_sec + 1) % 60 : (m_sec + 59) % 60; m_ls = 1; end
            endcase
        end
        if (m_mode == 0 || m_mode != old_mode || restart) m_ticks = 0;
        else m_ticks = m_ticks + 1;
        m_en = (m_mode == 0) && !(old_mode == 3 && m_mode == 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    function automatic int exp_blank();
        int b;
        b = (m_ticks / BLINK) % 2;
        case (m_mode)
            1: return b * 4;
            2: return b * 2;
            3: return b;
            default: return 0;
        endcase
    endfunction

    // Observed strobe statistics, compared against literal expectations.
    int cnt_lh = 0, cnt_lm = 0, cnt_ls = 0, cnt_all = 0;
    int rec_h = -1, rec_m = -1, rec_s = -1, rec_en = -1;
    int hour_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("set_mode",  int'(set_mode), m_mode);
            chk("en",        int'({en_hour, en_min, en_sec}), m_en ? 7 : 0);
            chk("load",      int'({load_hour, load_min, load_sec}), int'({m_lh, m_lm, m_ls}));
            chk("data_hour", int'(data_hour), m_hour);
            chk("data_min",  int'(data_min), m_min);
            chk("data_sec",  int'(data_sec), m_sec);
            chk("blank",     int'(blank_mask), exp_blank());
        end
        if (load_hour) cnt_lh++;
        if (load_min)  cnt_lm++;
        if (load_sec)  cnt_ls++;
        if (load_hour && !load_min) hour_q.push_back(int'(data_hour));
        if (load_hour && load_min && load_sec) begin
            cnt_all++;
            rec_h  = int'(data_hour);
            rec_m  = int'(data_min);
            rec_s  = int'(data_sec);
            rec_en = int'({en_hour, en_min, en_sec});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // mask: [0]=mode [1]=inc [2]=dec
    task automatic press(input logic [2:0] mask, input int hold, input int gap);
        $display("press keys=%03b hold=%0d gap=%0d state=%0d", mask, hold, gap, set_mode);
        key_mode_n = ~mask[0];
        key_inc_n  = ~mask[1];
        key_dec_n  = ~mask[2];
        step(hold);
        key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
        step(gap);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hourState = 7'(h); minState = 7'(m); secState = 7'(s);
        $display("time %0d:%0d:%0d", h, m, s);
    endtask

    int base, base2;

    initial begin
        rst_n = 1'b0;
        key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
        set_time(0, 0, 0);
        step(3);
        chk_en = 1'b1;
        step(3);

        // 1: reset release, idle
        rst_n = 1'b1;
        step(200);
        chk("t1_en", int'({en_hour, en_min, en_sec}), 7);
        chk("t1_loads", cnt_lh + cnt_lm + cnt_ls, 0);

        // 2: snapshot and hour wrap
        set_time(13, 45, 7);
        press(3'b001, 10, 10);
        chk("t2_mode", int'(set_mode), 1);
        chk("t2_en", int'({en_hour, en_min, en_sec}), 0);
        chk("t2_snap_h", int'(data_hour), 13);
        chk("t2_snap_m", int'(data_min), 45);
        chk("t2_snap_s", int'(data_sec), 7);
        chk("t2_model_h", m_hour, 13);
        base = cnt_lh;
        hour_q.delete();
        repeat (11) press(3'b010, 10, 10);
        chk("t2_pulses", cnt_lh - base, 11);
        chk("t2_qsize", hour_q.size(), 11);
        for (int i = 0; i < hour_q.size(); i++) chk("t2_seq", hour_q[i], (14 + i) % 24);
        chk("t2_wrap", int'(data_hour), 0);

        // 3: decrement wrap in SET_MIN and SET_SEC
        repeat (3) press(3'b001, 10, 10);
        set_time(5, 0, 0);
        press(3'b001, 10, 10);
        press(3'b001, 10, 10);
        base = cnt_lm;
        press(3'b100, 10, 10);
        chk("t3_min", int'(data_min), 59);
        chk("t3_min_pulse", cnt_lm - base, 1);
        press(3'b001, 10, 10);
        base = cnt_ls;
        press(3'b100, 10, 10);
        chk("t3_sec", int'(data_sec), 59);
        chk("t3_sec_pulse", cnt_ls - base, 1);

        // 4: glitch rejection and held key
        base = cnt_ls;
        $display("glitch inc 3 cycles");
        key_inc_n = 1'b0; step(3); key_inc_n = 1'b1; step(12);
        chk("t4_glitch_sec", int'(data_sec), 59);
        chk("t4_glitch_pulse", cnt_ls - base, 0);
        press(3'b010, 1000, 20);
        chk("t4_hold_sec", int'(data_sec), 0);
        chk("t4_hold_pulse", cnt_ls - base, 1);

        // 5: commit
        press(3'b001, 10, 10);
        set_time(13, 45, 7);
        press(3'b001, 10, 10);
        press(3'b010, 10, 10);
        press(3'b010, 10, 10);
        base = cnt_all;
        repeat (3) press(3'b001, 10, 10);
        chk("t5_commit_cnt", cnt_all - base, 1);
        chk("t5_commit_h", rec_h, 15);
        chk("t5_commit_m", rec_m, 45);
        chk("t5_commit_s", rec_s, 7);
        chk("t5_commit_en", rec_en, 0);
        chk("t5_mode", int'(set_mode), 0);
        chk("t5_en", int'({en_hour, en_min, en_sec}), 7);
        chk("t5_blank", int'(blank_mask), 0);

        // 6: simultaneous events, reset mid-edit, out-of-range snapshot
        press(3'b001, 10, 10);
        base = cnt_lh + cnt_lm + cnt_ls;
        press(3'b110, 10, 10);
        chk("t6_incdec_h", int'(data_hour), 13);
        chk("t6_incdec_load", cnt_lh + cnt_lm + cnt_ls - base, 0);
        press(3'b011, 10, 10);
        chk("t6_modeinc_mode", int'(set_mode), 2);
        chk("t6_modeinc_h", int'(data_hour), 13);
        chk("t6_modeinc_m", int'(data_min), 45);
        base2 = cnt_all;
        $display("reset mid-edit");
        rst_n = 1'b0; step(2); rst_n = 1'b1; step(2);
        chk("t6_rst_mode", int'(set_mode), 0);
        chk("t6_rst_noload", cnt_all - base2, 0);
        chk("t6_rst_min", int'(data_min), 0);
        set_time(30, 10, 20);
        press(3'b001, 10, 10);
        chk("t6_snap30", int'(data_hour), 0);
        chk("t6_model30", m_hour, 0);

        // Randomised phase, checked cycle by cycle against the model.
        for (int it = 0; it < 150; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                $display("random reset");
                rst_n = 1'b0; step($urandom_range(1, 3)); rst_n = 1'b1; step(2);
            end else if (r < 15) begin
                set_time($urandom_range(0, 31), $urandom_range(0, 70), $urandom_range(0, 70));
                step($urandom_range(1, 4));
            end else if (r < 25) begin
                int n;
                n = $urandom_range(1, 6);
                $display("bounce %0d cycles", n);
                repeat (n) begin
                    logic [2:0] b;
                    b = 3'($urandom_range(0, 7));
                    key_mode_n = b[0]; key_inc_n = b[1]; key_dec_n = b[2];
                    step(1);
                end
                key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
                step($urandom_range(4, 12));
            end else begin
                logic [2:0] m;
                m = 3'b001 << $urandom_range(0, 2);
                if ($urandom_range(0, 99) < 15) m = m | (3'b001 << $urandom_range(0, 2));
                press(m, $urandom_range(2, 14), $urandom_range(3, 14));
            end
        end

        step(20);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
